// File: rtl/result_uart_tx.sv
// UART transmitter for the ALU result byte: frames start, LSB-first data,
// optional parity and stop bits at a fixed baud, with registered outputs.
module result_uart_tx #(
    parameter int BUS_LEN      = 8,
    parameter int CLKS_PER_BIT = 10417,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic               i_clk,
    input  logic               reset,
    input  logic [BUS_LEN-1:0] i_data,
    input  logic               i_tx_start,
    output logic               o_tx,
    output logic               o_tx_busy,
    output logic               o_tx_done
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(BUS_LEN + STOP_BITS + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(BUS_LEN - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BUS_LEN-1:0] shift_q, shift_d;
    logic               parity_q, parity_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               baud_wrap;

    // The baud counter is reset on acceptance and only ever wraps, so every
    // bit boundary is an exact multiple of CLKS_PER_BIT from the start edge.
    assign baud_wrap = (baud_cnt_q == BAUD_LAST);

    // Start is a level request honoured only in IDLE; requests while busy are
    // dropped, and done rises on the same edge busy falls.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_wrap ? '0 : baud_cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                tx_d       = 1'b1;
                busy_d     = 1'b0;
                if (i_tx_start) begin
                    shift_d  = i_data;
                    parity_d = (PARITY == 2) ? ~^i_data : ^i_data;
                    state_d  = S_START;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            S_START: begin
                if (baud_wrap) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (baud_wrap) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_d[0];
                    end
                end
            end
            S_PARITY: begin
                if (baud_wrap) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (baud_wrap) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        state_d   = S_IDLE;
                        bit_cnt_d = '0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_tx      = tx_q;
    assign o_tx_busy = busy_q;
    assign o_tx_done = done_q;

endmodule
